// File: rtl/joypad_ctrl_pkg.sv
// Shared definitions for the P1/JOYP joypad controller.
// Holds the button bit positions on the raw button bus, the P1 select-field positions,
// the controller FSM states, and the helper that forms the readback nibble.
package joypad_ctrl_pkg;

  // Bit positions on iButtons (and on the debounced key vector)
  localparam int unsigned BTN_RIGHT  = 0;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_UP     = 2;
  localparam int unsigned BTN_DOWN   = 3;
  localparam int unsigned BTN_A      = 4;
  localparam int unsigned BTN_B      = 5;
  localparam int unsigned BTN_SELECT = 6;
  localparam int unsigned BTN_START  = 7;

  // Group-select bit positions inside the P1 register
  localparam int unsigned P1_SEL_P14 = 4;
  localparam int unsigned P1_SEL_P15 = 5;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } joy_state_e;

  // Active-low nibble seen through the select lines. A select bit at 1 deselects its
  // group, forcing that group's contribution to all-ones (released).
  function automatic logic [3:0] joy_raw_nibble(input logic [1:0] sel, input logic [7:0] keys);
    logic [3:0] dir;
    logic [3:0] act;
    dir = sel[0] ? 4'hF : keys[BTN_DOWN:BTN_RIGHT];
    act = sel[1] ? 4'hF : keys[BTN_START:BTN_A];
    return dir & act;
  endfunction

endpackage

// File: rtl/joypad_debounce.sv
// Single-bit input conditioner for one joypad button line.
// A two-flop synchroniser brings the raw line into the clock domain, then a counter
// requires DEBOUNCE_CYCLES consecutive cycles of disagreement before the stable output
// follows the synchronised value.
// Ports:
//   Clock   - system clock
//   Reset   - asynchronous, active-high reset (all state resets to released / 1)
//   iRaw    - raw, asynchronous, active-low button line
//   oStable - debounced, active-low button state
module joypad_debounce
  import joypad_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iRaw,
  output logic oStable
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            stable_q;
  logic            stable_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= iRaw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Counter tracks how long the synchronised value has disagreed with the stable state;
  // any agreement restarts the count, so short glitches never get through.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign oStable = stable_q;

endmodule

// File: rtl/joypad_ctrl.sv
// Joypad P1/JOYP register controller.
// Debounces the eight raw button lines, applies the CPU-written P14/P15 group select
// (holding the readback nibble for a settle period after every select write) and raises
// a level interrupt request on any visible high-to-low key transition.
// Ports:
//   Clock    - system clock
//   Reset    - asynchronous, active-high reset
//   iButtons - raw active-low buttons {Start,Select,B,A,Down,Up,Left,Right}
//   iSelWe   - one-cycle write strobe for the select bits
//   iSelData - select write data {P15,P14}
//   oP1      - readback {2'b11, P15, P14, nibble}
//   oBusy    - high while the select is settling
//   oIrqReq  - joypad interrupt request, held until acknowledged
//   iIrqAck  - one-cycle interrupt acknowledge
module joypad_ctrl
  import joypad_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES   = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iButtons,
  input  logic       iSelWe,
  input  logic [1:0] iSelData,
  output logic [7:0] oP1,
  output logic       oBusy,
  output logic       oIrqReq,
  input  logic       iIrqAck
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES - 1);

  logic [7:0]         keys;
  logic [3:0]         raw;
  joy_state_e         state_q;
  joy_state_e         state_d;
  logic [1:0]         sel_q;
  logic [1:0]         sel_d;
  logic [SettleW-1:0] settle_q;
  logic [SettleW-1:0] settle_d;
  logic [3:0]         nibble_q;
  logic [3:0]         nibble_d;
  logic               fall_q;
  logic               fall_d;
  logic               irq_q;
  logic               irq_d;

  for (genvar i = 0; i < 8; i++) begin : g_btn
    joypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .Clock  (Clock),
      .Reset  (Reset),
      .iRaw   (iButtons[i]),
      .oStable(keys[i])
    );
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      sel_q    <= 2'b11;
      settle_q <= '0;
      nibble_q <= 4'hF;
      fall_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      settle_q <= settle_d;
      nibble_q <= nibble_d;
      fall_q   <= fall_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    raw      = joy_raw_nibble(sel_q, keys);
    state_d  = state_q;
    sel_d    = sel_q;
    settle_d = settle_q;
    nibble_d = nibble_q;
    fall_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Falling-edge detection only where the nibble actually updates, so a held
        // nibble during settle cannot fire and the post-settle reload is still seen.
        nibble_d = raw;
        fall_d   = |(nibble_q & ~raw);
        if (iSelWe) begin
          sel_d    = iSelData;
          settle_d = SettleLoad;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (iSelWe) begin
          sel_d    = iSelData;
          settle_d = SettleLoad;
        end else if (settle_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pending edge beats a coincident acknowledge.
    irq_d = fall_q | (irq_q & ~iIrqAck);
  end

  always_comb begin
    oP1             = 8'hFF;
    oP1[P1_SEL_P14] = sel_q[0];
    oP1[P1_SEL_P15] = sel_q[1];
    oP1[3:0]        = nibble_q;
  end

  assign oBusy   = (state_q == ST_SETTLE);
  assign oIrqReq = irq_q;

endmodule

// File: tb/tb_joypad_ctrl.sv
module tb_joypad_ctrl;

  localparam int unsigned DEB = 16;
  localparam int unsigned SET = 4;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] iButtons;
  logic       iSelWe;
  logic [1:0] iSelData;
  logic [7:0] oP1;
  logic       oBusy;
  logic       oIrqReq;
  logic       iIrqAck;

  int n_checks = 0;
  int n_pass   = 0;
  int n_print  = 0;

  joypad_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .SETTLE_CYCLES  (SET)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .iButtons(iButtons),
    .iSelWe  (iSelWe),
    .iSelData(iSelData),
    .oP1     (oP1),
    .oBusy   (oBusy),
    .oIrqReq (oIrqReq),
    .iIrqAck (iIrqAck)
  );

  always #5 Clock = ~Clock;

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_pipe[$];      // input delay line, oldest entry is what the debouncer sees
  logic [7:0] m_deb;
  int         m_run[8];       // consecutive cycles a key has disagreed with its stable state
  logic [1:0] m_sel;
  logic [3:0] m_nib;
  int         m_busy_left;
  logic       m_pend;
  logic       m_irq;

  function automatic logic [3:0] m_view(input logic [1:0] sel, input logic [7:0] k);
    logic [3:0] v;
    for (int j = 0; j < 4; j++) v[j] = (sel[0] | k[j]) & (sel[1] | k[j+4]);
    return v;
  endfunction

  initial begin : model
    forever begin
      @(posedge Clock or posedge Reset);
      if (Reset) begin
        m_pipe = '{8'hFF, 8'hFF};
        m_deb = 8'hFF;
        for (int i = 0; i < 8; i++) m_run[i] = 0;
        m_sel = 2'b11;
        m_nib = 4'hF;
        m_busy_left = 0;
        m_pend = 1'b0;
        m_irq = 1'b0;
      end else begin
        logic [3:0] view;
        logic [7:0] synced;
        view   = m_view(m_sel, m_deb);
        synced = m_pipe[0];
        m_irq  = m_pend | (m_irq & ~iIrqAck);
        if (m_busy_left == 0) begin
          m_pend = |(m_nib & ~view);
          m_nib  = view;
        end else begin
          m_pend = 1'b0;
        end
        if (iSelWe) begin
          m_sel = iSelData;
          m_busy_left = SET;
        end else if (m_busy_left > 0) begin
          m_busy_left--;
        end
        for (int i = 0; i < 8; i++) begin
          if (synced[i] != m_deb[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
              m_deb[i] = synced[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
        void'(m_pipe.pop_front());
        m_pipe.push_back(iButtons);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Returns at the sample point just after the write has been captured.
  task automatic write_sel(input logic [1:0] d);
    iSelWe = 1'b1;
    iSelData = d;
    cyc(1);
    iSelWe = 1'b0;
  endtask

  task automatic ack_pulse;
    iIrqAck = 1'b1;
    cyc(1);
    iIrqAck = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    write_sel(2'b00);
    #3 Reset = 1'b1;
    #1;
    n_checks++;
    if (oP1 !== 8'hFF) $display("FAIL reset_async_p1: got %h want ff", oP1); else n_pass++;
    n_checks++;
    if (oBusy !== 1'b0) $display("FAIL reset_async_busy: got %b want 0", oBusy); else n_pass++;
    n_checks++;
    if (oIrqReq !== 1'b0) $display("FAIL reset_async_irq: got %b want 0", oIrqReq); else n_pass++;
    iButtons = 8'hFF;
    cyc(2);
    Reset = 1'b0;
    cyc(3);
    n_checks++;
    if (oP1 !== 8'hFF || oBusy !== 1'b0 || oIrqReq !== 1'b0)
      $display("FAIL reset_release: got p1=%h busy=%b irq=%b want ff 0 0", oP1, oBusy, oIrqReq);
    else n_pass++;
  endtask

  task automatic test_single_press;
    write_sel(2'b01);
    cyc(6);
    n_checks++;
    if (oP1 !== 8'hDF || oBusy !== 1'b0)
      $display("FAIL press_idle: got p1=%h busy=%b want df 0", oP1, oBusy);
    else n_pass++;
    iButtons = 8'hEF;
    cyc(18);
    n_checks++;
    if (oP1 !== 8'hDF) $display("FAIL press_early: got %h want df", oP1); else n_pass++;
    cyc(1);
    n_checks++;
    if (oP1 !== 8'hDE) $display("FAIL press_latency: got %h want de", oP1); else n_pass++;
    n_checks++;
    if (oIrqReq !== 1'b0) $display("FAIL press_irq_early: got %b want 0", oIrqReq); else n_pass++;
    cyc(1);
    n_checks++;
    if (oIrqReq !== 1'b1) $display("FAIL press_irq: got %b want 1", oIrqReq); else n_pass++;
    ack_pulse();
    n_checks++;
    if (oIrqReq !== 1'b0) $display("FAIL press_ack: got %b want 0", oIrqReq); else n_pass++;
    iButtons = 8'hFF;
    cyc(21);
    n_checks++;
    if (oP1 !== 8'hDF || oIrqReq !== 1'b0)
      $display("FAIL release_no_irq: got p1=%h irq=%b want df 0", oP1, oIrqReq);
    else n_pass++;
  endtask

  task automatic test_glitch;
    logic ok;
    write_sel(2'b10);
    cyc(6);
    n_checks++;
    if (oP1 !== 8'hEF) $display("FAIL glitch_idle: got %h want ef", oP1); else n_pass++;
    iButtons = 8'hF7;
    cyc(15);
    iButtons = 8'hFF;
    ok = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (oP1 !== 8'hEF || oIrqReq !== 1'b0) ok = 1'b0;
      cyc(1);
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL glitch_reject: got p1=%h irq=%b want ef 0", oP1, oIrqReq);
    else n_pass++;
    iButtons = 8'hF7;
    cyc(19);
    n_checks++;
    if (oP1 !== 8'hE7) $display("FAIL glitch_hold16: got %h want e7", oP1); else n_pass++;
    cyc(1);
    n_checks++;
    if (oIrqReq !== 1'b1) $display("FAIL glitch_irq: got %b want 1", oIrqReq); else n_pass++;
    iButtons = 8'hFF;
    ack_pulse();
    cyc(22);
    n_checks++;
    if (oP1 !== 8'hEF || oIrqReq !== 1'b0)
      $display("FAIL glitch_release: got p1=%h irq=%b want ef 0", oP1, oIrqReq);
    else n_pass++;
  endtask

  task automatic test_settle;
    logic ok;
    write_sel(2'b11);
    cyc(6);
    iButtons = 8'h7E;
    cyc(25);
    n_checks++;
    if (oP1 !== 8'hFF || oIrqReq !== 1'b0)
      $display("FAIL settle_pre: got p1=%h irq=%b want ff 0", oP1, oIrqReq);
    else n_pass++;
    write_sel(2'b10);
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (oBusy !== 1'b1 || oP1 !== 8'hEF) ok = 1'b0;
      if (k < 3) cyc(1);
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL settle_busy4: got busy=%b p1=%h want 1 ef", oBusy, oP1);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (oBusy !== 1'b0 || oP1 !== 8'hEF)
      $display("FAIL settle_end: got busy=%b p1=%h want 0 ef", oBusy, oP1);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (oP1 !== 8'hEE) $display("FAIL settle_load: got %h want ee", oP1); else n_pass++;
    cyc(1);
    n_checks++;
    if (oIrqReq !== 1'b1) $display("FAIL settle_irq: got %b want 1", oIrqReq); else n_pass++;
    ack_pulse();
    write_sel(2'b01);
    cyc(1);
    write_sel(2'b00);
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (oBusy !== 1'b1 || oP1 !== 8'hCE) ok = 1'b0;
      if (k < 3) cyc(1);
    end
    n_checks++;
    if (ok !== 1'b1) $display("FAIL settle_restart: got busy=%b p1=%h want 1 ce", oBusy, oP1);
    else n_pass++;
    cyc(2);
    n_checks++;
    if (oP1 !== 8'hC6 || oBusy !== 1'b0)
      $display("FAIL settle_final: got p1=%h busy=%b want c6 0", oP1, oBusy);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (oIrqReq !== 1'b1) $display("FAIL settle_final_irq: got %b want 1", oIrqReq); else n_pass++;
  endtask

  task automatic test_ack_collision;
    iButtons = 8'h7A;
    cyc(19);
    n_checks++;
    if (oP1 !== 8'hC2 || oIrqReq !== 1'b1)
      $display("FAIL collide_pre: got p1=%h irq=%b want c2 1", oP1, oIrqReq);
    else n_pass++;
    ack_pulse();
    n_checks++;
    if (oIrqReq !== 1'b1) $display("FAIL collide_set_wins: got %b want 1", oIrqReq); else n_pass++;
    cyc(1);
    ack_pulse();
    n_checks++;
    if (oIrqReq !== 1'b0) $display("FAIL collide_ack: got %b want 0", oIrqReq); else n_pass++;
  endtask

  task automatic test_mid_reset;
    write_sel(2'b01);
    cyc(6);
    iButtons = 8'hDF;
    cyc(10);
    Reset = 1'b1;
    cyc(1);
    n_checks++;
    if (oP1 !== 8'hFF) $display("FAIL midreset_p1: got %h want ff", oP1); else n_pass++;
    Reset = 1'b0;
    write_sel(2'b01);
    cyc(17);
    n_checks++;
    if (oP1 !== 8'hDF) $display("FAIL midreset_early: got %h want df", oP1); else n_pass++;
    cyc(1);
    n_checks++;
    if (oP1 !== 8'hDD) $display("FAIL midreset_latency: got %h want dd", oP1); else n_pass++;
    cyc(1);
    n_checks++;
    if (oIrqReq !== 1'b1) $display("FAIL midreset_irq: got %b want 1", oIrqReq); else n_pass++;
    iButtons = 8'hFF;
    ack_pulse();
    cyc(22);
  endtask

  task automatic test_random;
    int         hold[8];
    logic [7:0] btn;
    logic [7:0] exp_p1;
    btn = 8'hFF;
    for (int i = 0; i < 8; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      exp_p1 = {2'b11, m_sel, m_nib};
      n_checks++;
      if (oP1 !== exp_p1) begin
        if (n_print < 8) $display("FAIL rand_p1 cyc %0d: got %h want %h", c, oP1, exp_p1);
        n_print++;
      end else n_pass++;
      n_checks++;
      if (oBusy !== (m_busy_left > 0)) begin
        if (n_print < 8) $display("FAIL rand_busy cyc %0d: got %b want %b", c, oBusy, m_busy_left > 0);
        n_print++;
      end else n_pass++;
      n_checks++;
      if (oIrqReq !== m_irq) begin
        if (n_print < 8) $display("FAIL rand_irq cyc %0d: got %b want %b", c, oIrqReq, m_irq);
        n_print++;
      end else n_pass++;
      for (int i = 0; i < 8; i++) begin
        if (hold[i] == 0) begin
          btn[i]  = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
          hold[i] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 15) : $urandom_range(16, 45);
        end else begin
          hold[i]--;
        end
      end
      iButtons = btn;
      iSelWe   = ($urandom_range(0, 49) == 0);
      iSelData = 2'($urandom_range(0, 3));
      iIrqAck  = ($urandom_range(0, 9) == 0);
      cyc(1);
    end
    iSelWe  = 1'b0;
    iIrqAck = 1'b0;
  endtask

  initial begin
    Reset    = 1'b1;
    iButtons = 8'hFF;
    iSelWe   = 1'b0;
    iSelData = 2'b11;
    iIrqAck  = 1'b0;
    cyc(2);
    Reset = 1'b0;
    cyc(2);
    test_reset();
    test_single_press();
    test_glitch();
    test_settle();
    test_ack_collision();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/joypad_ctrl.md
Name: joypad_ctrl

Overview:
Controller for the joypad P1/JOYP register ($FF00). It synchronises and debounces the eight raw button lines. It applies the CPU-written P14/P15 group select, with a settle delay after every select write, and presents the 8-bit readback. On any visible high-to-low key transition it raises the joypad interrupt request (IF bit 4), which stays held until the interrupt controller acknowledges it.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles a raw line needs before its debounced state changes (range 1..65535).
SETTLE_CYCLES, 4, cycles after a select write during which the readback nibble holds its previous value (range 1..255).

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
iButtons  in  8  raw, active-low: [0]Right [1]Left [2]Up [3]Down [4]A [5]B [6]Select [7]Start
iSelWe  in  1  one-cycle write strobe to P1
iSelData  in  2  write data {P15,P14} (CPU data bits 5:4)
oP1  out  8  readback {2'b11, P15, P14, nibble[3:0]}, active-low
oBusy  out  1  high while in SETTLE
oIrqReq  out  1  joypad interrupt request, level
iIrqAck  in  1  one-cycle acknowledge; clears oIrqReq

Behaviour:
- Reset (async assert, sync release) sets:
  - select = 2'b11
  - debounced state = 8'hFF
  - debounce counters = 0
  - nibble = 4'hF
  - oP1 = 8'hFF, oBusy = 0, oIrqReq = 0
  - FSM = IDLE
- Input sync: two-flop synchroniser per iButtons bit, reset value 1.
- Debounce, per bit:
  - If the synced value equals the debounced state, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced state takes the synced value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes state.
- Raw nibble (combinational):
  - dir = debounced[3:0], act = debounced[7:4].
  - raw = (P14 ? 4'hF : dir) & (P15 ? 4'hF : act).
  - Select 2'b00 ANDs both groups; select 2'b11 gives 4'hF.
- Latency: press → synced (2 cycles) → debounced (+DEBOUNCE_CYCLES) → nibble register (+1).
- FSM, two states:
  - IDLE: nibble <= raw every cycle. On iSelWe: select <= iSelData, settle counter <= SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: nibble holds its value, oBusy = 1, counter decrements. At 0 → IDLE, and nibble loads raw on the next IDLE cycle.
  - iSelWe during SETTLE updates select and restarts the counter.
- oP1[5:4] reflects the new select immediately after the write (next cycle).
- Interrupt:
  - A falling edge is any bit where nibble_prev = 1 and nibble_next = 0, evaluated only on cycles where the nibble register updates (IDLE).
  - A falling edge sets oIrqReq on the next clock.
  - A nibble change caused by a select change (after settle) also counts if a bit falls.
  - iIrqAck clears oIrqReq.
  - Simultaneous ack and new edge: oIrqReq remains 1 (set wins).
  - Rising edges (releases) never set it.
- Reset asserted mid-debounce or mid-settle aborts immediately to reset values.
- No $display or simulation-only side effects in RTL paths.

Decomposition:
- Shared package or collaterals header holds:
  - button index constants (BTN_RIGHT..BTN_START)
  - P1 field positions (P1_SEL_P14 = 4, P1_SEL_P15 = 5)
  - FSM state encodings (ST_IDLE, ST_SETTLE)
- Sub-module joypad_debounce: one bit, parameter DEBOUNCE_CYCLES, ports Clock, Reset, iRaw, oStable. It includes its two-flop synchroniser and is instantiated 8× via generate.
- The top level holds the select register, FSM, nibble register and IRQ logic.

Test Plan:
- Reset check: assert Reset mid-cycle → oP1 = 8'hFF, oIrqReq = 0, oBusy = 0 asynchronously; hold iButtons = 8'hFF, release → values unchanged.
- Single press: write select 2'b01 (P15 = 0, P14 = 1), wait for settle, press A (iButtons = 8'hEF) → oP1 = 8'hDE exactly 2+16+1 cycles after the press, oIrqReq = 1 the cycle after; pulse iIrqAck → oIrqReq = 0; release A → oP1 = 8'hDF, no IRQ.
- Glitch rejection: select 2'b10, pulse Down low for 15 cycles → oP1 stays 8'hEF, no IRQ; hold 16 cycles → oP1 = 8'hE7, IRQ set.
- Select settle: Right and Start held and debounced, select 2'b11 → write 2'b10: oBusy = 1 for 4 cycles, nibble stays 4'hF, then oP1 = 8'hEE with IRQ; write 2'b00 during settle restarts the 4-cycle count, final oP1 = 8'hC6.
- Ack/edge collision: with oIrqReq = 1, assert iIrqAck in the same cycle a new falling edge registers → oIrqReq remains 1.
- Mid-operation reset: press B and assert Reset 8 cycles into debounce, then deassert with B still held → debounce restarts from 0; oP1 changes only after a full 2+16+1 cycles.
